// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and default width for the
// bit-serial adder controller.
package serial_add_pkg;

  // Default operand/result width.
  localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Half-adder sum bit; the carry is a plain AND at the call site.
  function automatic logic half_sum(input logic x, input logic y);
    return x ^ y;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: 1-bit full adder built from two half-add stages and an OR
// that merges the two partial carries.
module fa_cell
  import serial_add_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;

  // First stage adds the operand bits, second stage folds in the carry.
  assign ha1_s = half_sum(x, y);
  assign ha1_c = x & y;
  assign s     = half_sum(ha1_s, cin);
  assign ha2_c = ha1_s & cin;
  assign co    = ha1_c | ha2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands one bit per clock, LSB
// first, through a single fa_cell. Handshaked input (in_valid/in_ready)
// and output (out_valid/out_ready); result held until accepted and kept
// visible until the next accept.
// Optional feature macro SERIAL_ADD_SUB_EN adds a 'sub' input selecting
// a - b (b inverted, initial carry 1, cout = 1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1: invert b at load and seed the carry.
  assign b_load_s     = sub ? ~b : b;
  assign carry_load_s = sub;
`else
  assign b_load_s     = b;
  assign carry_load_s = 1'b0;
`endif

  fa_cell u_fa (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_sr_q  <= {WIDTH{1'b0}};
      b_sr_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath update: load on accept, one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
          a_sr_d  = a;
          b_sr_d  = b_load_s;
          sum_d   = {WIDTH{1'b0}};
          carry_d = carry_load_s;
          cout_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cout_d  = fa_co;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags decode directly from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one operation, check latency/result, then release the result.
  task automatic do_op(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vsub, input logic [W-1:0] esum, input logic ecout);
    int n;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready_before got=%b exp=1", nm, in_ready);
    end
    a = va; b = vb; sub = vsub; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    a = ~va; b = ~vb; sub = ~vsub;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      in_valid = n[0];
      step();
      n++;
    end
    in_valid = 1'b0;
    total++;
    if (n !== W) begin
      bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, n, W);
    end
    total++;
    if (sum !== esum || cout !== ecout) begin
      bad++; $display("FAIL %s result got=%h/%b exp=%h/%b", nm, sum, cout, esum, ecout);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== esum || cout !== ecout) begin
      bad++; $display("FAIL %s release got=rdy%b ov%b bsy%b %h/%b exp=rdy1 ov0 bsy0 %h/%b",
                      nm, in_ready, out_valid, busy, sum, cout, esum, ecout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    step(); step();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      bad++; $display("FAIL reset_state got=rdy%b ov%b bsy%b %h/%b exp=rdy1 ov0 bsy0 00/0",
                      in_ready, out_valid, busy, sum, cout);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);
    do_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    do_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_stall();
    int n;
    a = 8'h0F; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin step(); n++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL stall_reach_done got=%b exp=1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~i[0]; a = 8'h33; b = 8'h44;
      step();
      total++;
      if (sum !== 8'h10 || cout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%b rdy%b ov%b exp=10/0 rdy0 ov1",
                        i, sum, cout, in_ready, out_valid);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h10) begin
      bad++; $display("FAIL stall_release got=rdy%b ov%b %h exp=rdy1 ov0 10", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_midrun_reset();
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got=rdy%b ov%b bsy%b %h/%b exp=rdy1 ov0 bsy0 00/0",
                      in_ready, out_valid, busy, sum, cout);
    end
    do_op("after_reset_03_04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);
  endtask

  task automatic test_rst_dominates();
    a = 8'h11; b = 8'h22; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_dominates got=rdy%b bsy%b exp=rdy1 bsy0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] es [3];
    logic         ec [3];
    int acc_n, res_n, cyc, last_acc;
    logic acc_now;
    va[0] = 8'h12; vb[0] = 8'h34; es[0] = 8'h46; ec[0] = 1'b0;
    va[1] = 8'hF0; vb[1] = 8'h20; es[1] = 8'h10; ec[1] = 1'b1;
    va[2] = 8'h7F; vb[2] = 8'h7F; es[2] = 8'hFE; ec[2] = 1'b0;
    acc_n = 0; res_n = 0; cyc = 0; last_acc = 0;
    a = va[0]; b = vb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (res_n < 3 && cyc < 100) begin
      acc_now = in_ready;
      step();
      cyc++;
      if (acc_now === 1'b1 && acc_n < 3) begin
        if (acc_n > 0) begin
          total++;
          if (cyc - last_acc !== W + 2) begin
            bad++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", acc_n, cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        acc_n++;
        if (acc_n < 3) begin a = va[acc_n]; b = vb[acc_n]; end
        else begin in_valid = 1'b0; end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (sum !== es[res_n] || cout !== ec[res_n]) begin
          bad++; $display("FAIL b2b_result%0d got=%h/%b exp=%h/%b", res_n, sum, cout, es[res_n], ec[res_n]);
        end
        res_n++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (res_n !== 3) begin
      bad++; $display("FAIL b2b_timeout got=%0d results exp=3", res_n);
    end
    step();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
    do_op("sub_07_05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_midrun_reset();
    test_rst_dominates();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  requester presents operands a, b.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 out_valid  output  1  sum/cout hold a finished result; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 sum  output  WIDTH  result, LSB first assembled.
REQ-011 cout  output  1  carry out of bit WIDTH-1.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL add a and b bit-serially through one 1-bit full-adder cell, one bit per clock, LSB first.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready, RUN->DONE when bit counter equals WIDTH-1, DONE->IDLE on out_valid&&out_ready.
REQ-015 On accept, a and b SHALL be latched into shift registers, carry register cleared to 0, bit counter cleared to 0, sum register cleared to 0.
REQ-016 Each RUN cycle: sum_bit = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0], b_sr[0], carry); sum_bit shifted into sum MSB, sum shifts right; a_sr, b_sr shift right; counter increments.
REQ-017 Latency: with the accepting edge numbered 0, out_valid SHALL be high immediately after edge WIDTH; RUN lasts exactly WIDTH cycles.
REQ-018 In DONE, sum and cout SHALL hold stable until the handshake; out_ready held low stalls indefinitely.
REQ-019 in_valid outside IDLE SHALL be ignored; a/b changes during RUN SHALL not affect the result.
REQ-020 Back-to-back: with out_ready tied high, DONE lasts one cycle; minimum period per operation is WIDTH+2 cycles.
REQ-021 Wrap-around: result is modulo 2^WIDTH, overflow reported only via cout.
REQ-022 sum and cout SHALL keep the last result after DONE->IDLE until the next accept.

Reset
REQ-023 rst high at any edge, including mid-RUN or in DONE, SHALL abort the operation: state IDLE, counter 0, carry 0, shift registers 0, sum 0, cout 0.
REQ-024 Output values in/after reset: in_ready 1, out_valid 0, busy 0, sum 0, cout 0.
REQ-025 rst SHALL dominate a same-cycle in_valid or out_ready handshake.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_EN: when defined, an input port sub (1 bit, sampled with a/b on accept) SHALL be present; sub=1 latches ~b and initial carry 1, giving a-b with cout=1 meaning no borrow.
REQ-027 Without SERIAL_ADD_SUB_EN: no sub port; behaviour is addition only per REQ-015/016.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the default WIDTH constant.
REQ-029 The 1-bit full-adder cell SHALL be a sub-module fa_cell (inputs x, y, cin; outputs s, co), built from two half-add stages plus OR.

Verification
REQ-030 WIDTH=8, accept a=0x0F, b=0x01 -> out_valid high after edge 8, sum=0x10, cout=0.
REQ-031 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xA5, b=0x5A -> sum=0xFF, cout=0.
REQ-032 Result pending, out_ready low 5 cycles while in_valid pulses -> sum/cout stable, in_ready 0, no new accept; out_ready high -> IDLE next cycle.
REQ-033 rst asserted on the 3rd RUN cycle -> next cycle state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, cout 0; subsequent a=0x03, b=0x04 -> sum=0x07.
REQ-034 SERIAL_ADD_SUB_EN defined, sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-035 out_ready tied high, in_valid tied high, 3 operations -> accepts spaced exactly WIDTH+2 cycles, all results correct.
